multi_cycle_controller: RTL and testbench

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

---
 rtl/mips_pkg.sv | 69 ++++++
 rtl/controller_out_decode.sv | 116 +++++++++++
 rtl/multi_cycle_controller.sv | 103 ++++++++++
 tb/tb_multi_cycle_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, state codes
// and the datapath mux select values.
package mips_pkg;

  // Supported opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Controller states; codes 14 and 15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_JALEX   = 4'd12,
    S_BNEEX   = 4'd13
  } state_t;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Write-register select
  localparam logic [1:0] REGDEST_RT = 2'b00;
  localparam logic [1:0] REGDEST_RD = 2'b01;
  localparam logic [1:0] REGDEST_RA = 2'b10;

  // Write-data select
  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_RT      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  // ALU control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // True for every opcode the controller knows how to sequence
  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW:
        is_supported = 1'b1;
      default:
        is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/controller_out_decode.sv
// Moore-style output decode: control strobes from the current state, with the
// FETCH write enables qualified by memory readiness. All outputs are forced
// low while reset is asserted.
module controller_out_decode
  import mips_pkg::*;
#(
  parameter int ALUOP_W = 2
) (
  input  logic               rst_n,
  input  logic [3:0]         state,
  input  logic               mem_ready,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               branch,
  output logic               branch_ne,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic [1:0]         reg_dest,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op
);

  logic [1:0] alu_op_enc;

  // Per-state control decode; anything not named for a state stays 0
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dest   = REGDEST_RT;
    mem_to_reg = MEMTOREG_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUSRCB_RT;
    alu_op_enc = ALUOP_ADD;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALUSRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = ALUSRCB_IMM_SH2;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUSRCB_IMM;
        end
        S_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = MEMTOREG_MDR;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_RTYPEEX: begin
          alu_src_a  = 1'b1;
          alu_op_enc = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          reg_write = 1'b1;
          reg_dest  = REGDEST_RD;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUSRCB_IMM;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_BEQEX: begin
          alu_src_a  = 1'b1;
          alu_op_enc = ALUOP_SUB;
          branch     = 1'b1;
          pc_src     = PCSRC_ALUOUT;
        end
        S_BNEEX: begin
          alu_src_a  = 1'b1;
          alu_op_enc = ALUOP_SUB;
          branch_ne  = 1'b1;
          pc_src     = PCSRC_ALUOUT;
        end
        S_JEX: begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JUMP;
        end
        S_JALEX: begin
          pc_write   = 1'b1;
          pc_src     = PCSRC_JUMP;
          reg_write  = 1'b1;
          reg_dest   = REGDEST_RA;
          mem_to_reg = MEMTOREG_PC;
        end
        default: ;
      endcase
    end
  end

  // Encodings live in the low two bits; wider ALUOp buses are zero-extended
  assign alu_op = ALUOP_W'(alu_op_enc);

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control unit: state register and next-state sequencing,
// with output strobes produced by controller_out_decode.
module multi_cycle_controller
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int ALUOP_W     = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [5:0]         OpCode,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               Branch,
  output logic               BranchNe,
  output logic [1:0]         PCSrc,
  output logic               RegWrite,
  output logic [1:0]         RegDest,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         State,
  output logic               IllegalOp
);

  state_t state_q;
  state_t state_d;
  logic   mem_ready_eff;

  // Without wait support the memory is assumed to always answer in one cycle
  assign mem_ready_eff = MEM_WAIT_EN ? MemReady : 1'b1;

  // State register; reset returns to FETCH without waiting for a clock edge
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state sequencing; OpCode is looked at only in DECODE and MEMADR
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready_eff) state_d = S_DECODE;
      S_DECODE: begin
        case (OpCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_J:         state_d = S_JEX;
          OP_JAL:       state_d = S_JALEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (OpCode == OP_LW)      state_d = S_MEMRD;
        else if (OpCode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:   if (mem_ready_eff) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready_eff) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_BNEEX, S_JEX, S_JALEX:
        state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Illegal-opcode flag is tied to the DECODE cycle that rejects it
  assign IllegalOp = RST && (state_q == S_DECODE) && !is_supported(OpCode);
  assign State     = state_q;

  controller_out_decode #(
    .ALUOP_W (ALUOP_W)
  ) u_out_decode (
    .rst_n      (RST),
    .state      (state_q),
    .mem_ready  (mem_ready_eff),
    .iord       (IorD),
    .mem_read   (MemRead),
    .mem_write  (MemWrite),
    .ir_write   (IRWrite),
    .pc_write   (PCWrite),
    .branch     (Branch),
    .branch_ne  (BranchNe),
    .pc_src     (PCSrc),
    .reg_write  (RegWrite),
    .reg_dest   (RegDest),
    .mem_to_reg (MemtoReg),
    .alu_src_a  (ALUSrcA),
    .alu_src_b  (ALUSrcB),
    .alu_op     (ALUOp)
  );

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: one instance with memory wait
// support, one without. Expected state/output vectors go into a scoreboard
// queue as each step is driven and are compared when the outputs are sampled.
module tb_multi_cycle_controller;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         AD = 6'b001000, BQ = 6'b000100, BN = 6'b000101,
                         JJ = 6'b000010, JL = 6'b000011, XX = 6'b111111;

  typedef struct packed {
    logic       iord, memread, memwrite, irwrite, pcwrite, branch, branchne;
    logic [1:0] pcsrc;
    logic       regwrite;
    logic [1:0] regdest, memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb, aluop;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] OpCode = LW;
  logic       MemReady = 1'b1;

  logic       iord1, mr1, mw1, irw1, pcw1, br1, bne1, rw1, asa1, ill1;
  logic [1:0] pcs1, rd1, m2r1, asb1, aop1;
  logic [3:0] st1;
  logic       iord2, mr2, mw2, irw2, pcw2, br2, bne2, rw2, asa2, ill2;
  logic [1:0] pcs2, rd2, m2r2, asb2, aop2;
  logic [3:0] st2;
  outs_t      outs1, outs2;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  multi_cycle_controller dut (
    .CLK(CLK), .RST(RST), .OpCode(OpCode), .MemReady(MemReady),
    .IorD(iord1), .MemRead(mr1), .MemWrite(mw1), .IRWrite(irw1),
    .PCWrite(pcw1), .Branch(br1), .BranchNe(bne1), .PCSrc(pcs1),
    .RegWrite(rw1), .RegDest(rd1), .MemtoReg(m2r1), .ALUSrcA(asa1),
    .ALUSrcB(asb1), .ALUOp(aop1), .State(st1), .IllegalOp(ill1)
  );

  multi_cycle_controller #(.MEM_WAIT_EN(1'b0)) dut_nowait (
    .CLK(CLK), .RST(RST), .OpCode(OpCode), .MemReady(MemReady),
    .IorD(iord2), .MemRead(mr2), .MemWrite(mw2), .IRWrite(irw2),
    .PCWrite(pcw2), .Branch(br2), .BranchNe(bne2), .PCSrc(pcs2),
    .RegWrite(rw2), .RegDest(rd2), .MemtoReg(m2r2), .ALUSrcA(asa2),
    .ALUSrcB(asb2), .ALUOp(aop2), .State(st2), .IllegalOp(ill2)
  );

  assign outs1 = {iord1, mr1, mw1, irw1, pcw1, br1, bne1, pcs1, rw1, rd1, m2r1,
                  asa1, asb1, aop1, ill1};
  assign outs2 = {iord2, mr2, mw2, irw2, pcw2, br2, bne2, pcs2, rw2, rd2, m2r2,
                  asa2, asb2, aop2, ill2};

  // Reference output table, written from the state descriptions
  function automatic outs_t model(input logic [3:0] st, input logic mr,
                                  input logic rst_v, input logic ill);
    outs_t o = '0;
    if (rst_v) begin
      case (st)
        4'd0:  begin o.memread = 1; o.alusrcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
        4'd1:  begin o.alusrcb = 2'b11; o.illegal = ill; end
        4'd2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
        4'd3:  begin o.iord = 1; o.memread = 1; end
        4'd4:  begin o.regwrite = 1; o.memtoreg = 2'b01; end
        4'd5:  begin o.iord = 1; o.memwrite = 1; end
        4'd6:  begin o.alusrca = 1; o.aluop = 2'b10; end
        4'd7:  begin o.regwrite = 1; o.regdest = 2'b01; end
        4'd8:  begin o.alusrca = 1; o.aluop = 2'b01; o.branch = 1; o.pcsrc = 2'b01; end
        4'd9:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
        4'd10: o.regwrite = 1;
        4'd11: begin o.pcwrite = 1; o.pcsrc = 2'b10; end
        4'd12: begin
          o.pcwrite = 1; o.pcsrc = 2'b10; o.regwrite = 1;
          o.regdest = 2'b10; o.memtoreg = 2'b10;
        end
        4'd13: begin o.alusrca = 1; o.aluop = 2'b01; o.branchne = 1; o.pcsrc = 2'b01; end
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Push the expected vector for the current cycle, then sample 1 ns later
  task automatic sample(input string tag, input logic [3:0] st, input bit nowait);
    exp_t e;
    logic ill;
    logic mr_m;
    ill  = (st == 4'd1) && !(OpCode inside {LW, SW, RT, AD, BQ, BN, JJ, JL});
    mr_m = nowait ? 1'b1 : MemReady;
    sb.push_back('{st: st, o: model(st, mr_m, RST, ill)});
    #1;
    e = sb.pop_front();
    if (nowait) check(tag, {st2, outs2}, e);
    else        check(tag, {st1, outs1}, e);
  endtask

  // One clock of directed stimulus, called just after a falling edge
  task automatic step(input string tag, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input bit nowait = 1'b0);
    OpCode   = op;
    MemReady = mr;
    sample(tag, st, nowait);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles with MemReady high: State 0, all outputs 0
    @(negedge CLK);
    for (int i = 0; i < 3; i++) step("reset_hold", LW, 1'b1, 4'd0);
    RST = 1'b1;
    step("fetch_after_rst", LW, 1'b1, 4'd0);

    // lw with two MEMRD stall cycles; OpCode churn outside DECODE/MEMADR
    step("lw_decode",  LW, 1'b1, 4'd1);
    step("lw_memadr",  LW, 1'b1, 4'd2);
    step("lw_memrd_0", SW, 1'b0, 4'd3);
    step("lw_memrd_1", XX, 1'b0, 4'd3);
    step("lw_memrd_2", RT, 1'b1, 4'd3);
    step("lw_memwb",   JJ, 1'b0, 4'd4);
    step("fetch_stall", SW, 1'b0, 4'd0);

    // sw with one MEMWR stall cycle
    step("sw_fetch",   SW, 1'b1, 4'd0);
    step("sw_decode",  SW, 1'b1, 4'd1);
    step("sw_memadr",  SW, 1'b1, 4'd2);
    step("sw_memwr_0", SW, 1'b0, 4'd5);
    step("sw_memwr_1", LW, 1'b1, 4'd5);

    // jal
    step("jal_fetch",  JL, 1'b1, 4'd0);
    step("jal_decode", JL, 1'b1, 4'd1);
    step("jal_ex",     BQ, 1'b0, 4'd12);

    // unsupported opcode
    step("ill_fetch",  XX, 1'b1, 4'd0);
    step("ill_decode", XX, 1'b1, 4'd1);

    // beq / bne
    step("beq_fetch",  BQ, 1'b1, 4'd0);
    step("beq_decode", BQ, 1'b1, 4'd1);
    step("beq_ex",     BQ, 1'b1, 4'd8);
    step("bne_fetch",  BN, 1'b1, 4'd0);
    step("bne_decode", BN, 1'b1, 4'd1);
    step("bne_ex",     BN, 1'b1, 4'd13);

    // R-type, addi, j
    step("rt_fetch",   RT, 1'b1, 4'd0);
    step("rt_decode",  RT, 1'b1, 4'd1);
    step("rt_ex",      LW, 1'b1, 4'd6);
    step("rt_wb",      LW, 1'b1, 4'd7);
    step("addi_fetch", AD, 1'b1, 4'd0);
    step("addi_decode",AD, 1'b1, 4'd1);
    step("addi_ex",    AD, 1'b1, 4'd9);
    step("addi_wb",    AD, 1'b1, 4'd10);
    step("j_fetch",    JJ, 1'b1, 4'd0);
    step("j_decode",   JJ, 1'b1, 4'd1);
    step("j_ex",       JJ, 1'b1, 4'd11);

    // Reset asserted mid-cycle during a MEMWR stall
    step("swr_fetch",  SW, 1'b1, 4'd0);
    step("swr_decode", SW, 1'b1, 4'd1);
    step("swr_memadr", SW, 1'b1, 4'd2);
    OpCode   = SW;
    MemReady = 1'b0;
    sample("swr_memwr_stall", 4'd5, 1'b0);
    #2 RST = 1'b0;
    sample("rst_async_memwr", 4'd0, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    step("rst_async_hold", SW, 1'b0, 4'd0);

    // Without wait support MemReady is ignored: lw takes exactly 5 cycles
    RST = 1'b1;
    OpCode = LW;
    MemReady = 1'b0;
    sample("wait_fetch_stall", 4'd0, 1'b0);
    step("nw_fetch",  LW, 1'b0, 4'd0, 1'b1);
    step("nw_decode", LW, 1'b0, 4'd1, 1'b1);
    step("nw_memadr", LW, 1'b0, 4'd2, 1'b1);
    step("nw_memrd",  LW, 1'b0, 4'd3, 1'b1);
    step("nw_memwb",  LW, 1'b0, 4'd4, 1'b1);
    step("nw_back",   LW, 1'b0, 4'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
